im_boot_ctrl: RTL and testbench

Boot/load controller and access sequencer for the single-cycle CPU's instruction memory. After reset it holds the CPU in stall and accepts a byte stream from the loader port. It assembles big-endian 32-bit words and writes them into a write-capable instruction RAM. It then releases the CPU and hands the RAM read port to instruction fetch. It sits between the loader, the CPU fetch stage and the instruction RAM.

---
 rtl/im_pkg.sv | 16 +
 rtl/im_word_packer.sv | 49 ++++
 rtl/im_boot_ctrl.sv | 139 +++++++++++++
 tb/tb_im_boot_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/im_pkg.sv
// Shared types and defaults for the instruction-memory boot controller.
// Optional checksum output is enabled with IM_BOOT_CHECKSUM_EN.
package im_pkg;

    localparam int IM_DEPTH = 128;
    localparam int IM_AW    = 7;

    localparam logic [31:0] NOP_WORD = 32'h0;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_FLUSH,
        ST_RUN
    } state_e;

endpackage

// File: rtl/im_word_packer.sv
// Assembles big-endian 32-bit words from a byte stream.
// Emits word_valid/word on the fourth byte or on a final byte.
module im_word_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        accept,
    input  logic [7:0]  ld_byte,
    input  logic        last,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  idx_q, idx_d;
    logic [31:0] asm_q, asm_d;

    // asm_q keeps unfilled byte lanes at zero, so a short word is zero-padded.
    always_comb begin
        word = asm_q;
        unique case (idx_q)
            2'd0: word[31:24] = ld_byte;
            2'd1: word[23:16] = ld_byte;
            2'd2: word[15:8]  = ld_byte;
            2'd3: word[7:0]   = ld_byte;
            default: word = asm_q;
        endcase
        word_valid = accept && ((idx_q == 2'd3) || last);
        idx_d = idx_q;
        asm_d = asm_q;
        if (clr || word_valid) begin
            idx_d = 2'd0;
            asm_d = '0;
        end else if (accept) begin
            idx_d = idx_q + 2'd1;
            asm_d = word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= 2'd0;
            asm_q <= '0;
        end else begin
            idx_q <= idx_d;
            asm_q <= asm_d;
        end
    end

endmodule

// File: rtl/im_boot_ctrl.sv
// Boot loader FSM and instruction-RAM access sequencer.
// Define IM_BOOT_CHECKSUM_EN to add the ld_sum running-sum output.
module im_boot_ctrl
    import im_pkg::*;
#(
    parameter int DEPTH = IM_DEPTH,
    parameter int AW    = IM_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ld_start,
    input  logic          ld_valid,
    input  logic [7:0]    ld_byte,
    input  logic          ld_last,
    output logic          ld_ready,
    output logic [AW:0]   ld_count,
    output logic          ld_ovf,
    input  logic [29:0]   fetch_addr,
    output logic [31:0]   fetch_dout,
    output logic          cpu_stall,
    output logic          addr_err,
`ifdef IM_BOOT_CHECKSUM_EN
    output logic [31:0]   ld_sum,
`endif
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    state_e        state_q, state_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          err_q, err_d;
    logic          we_q, we_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [31:0]   wdata_q, wdata_d;

    logic          full, accept, in_range, run;
    logic          word_valid;
    logic [31:0]   word;

    assign full     = (cnt_q == (AW+1)'(DEPTH));
    assign run      = (state_q == ST_RUN);
    assign ld_ready = (state_q == ST_LOAD) && !full;
    assign accept   = ld_valid && ld_ready && !ld_start;
    assign in_range = (fetch_addr[29:AW] == '0);

    im_word_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (ld_start),
        .accept     (accept),
        .ld_byte    (ld_byte),
        .last       (ld_last),
        .word_valid (word_valid),
        .word       (word)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            ST_LOAD: begin
                if (word_valid) begin
                    we_d    = 1'b1;
                    waddr_d = cnt_q[AW-1:0];
                    wdata_d = word;
                    cnt_d   = cnt_q + 1'b1;
                    if (ld_last) state_d = ST_FLUSH;
                end else if (full && ld_valid) begin
                    ovf_d   = 1'b1;
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: state_d = ST_RUN;
            ST_RUN:   if (!in_range) err_d = 1'b1;
            default:  state_d = ST_LOAD;
        endcase
        // Restart keeps waddr/wdata so an already registered write completes.
        if (ld_start) begin
            state_d = ST_LOAD;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_LOAD;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

`ifdef IM_BOOT_CHECKSUM_EN
    logic [31:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (ld_start)        sum_d = '0;
        else if (word_valid) sum_d = sum_q + word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sum_q <= '0;
        else        sum_q <= sum_d;
    end

    assign ld_sum = sum_q;
`endif

    assign ld_count   = cnt_q;
    assign ld_ovf     = ovf_q;
    assign addr_err   = err_q;
    assign cpu_stall  = !run;
    assign mem_we     = we_q;
    assign mem_wdata  = wdata_q;
    assign mem_addr   = run ? fetch_addr[AW-1:0] : waddr_q;
    assign fetch_dout = (run && in_range) ? mem_rdata : NOP_WORD;

endmodule

// File: tb/tb_im_boot_ctrl.sv
// Self-checking bench for im_boot_ctrl with a behavioural RAM and image model.
// Define IM_BOOT_CHECKSUM_EN for both files to cover ld_sum.
module tb_im_boot_ctrl;

    localparam int DEPTH = 128;
    localparam int AW    = 7;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ld_start = 1'b0;
    logic          ld_valid = 1'b0;
    logic [7:0]    ld_byte = 8'h0;
    logic          ld_last = 1'b0;
    logic          ld_ready;
    logic [AW:0]   ld_count;
    logic          ld_ovf;
    logic [29:0]   fetch_addr = '0;
    logic [31:0]   fetch_dout;
    logic          cpu_stall;
    logic          addr_err;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
`ifdef IM_BOOT_CHECKSUM_EN
    logic [31:0]   ld_sum;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] ram [DEPTH];
    logic [7:0]  bq [$];
    int          wlog_a [$];
    logic [31:0] wlog_d [$];

    always #5 clk = ~clk;

    im_boot_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ld_start   (ld_start),
        .ld_valid   (ld_valid),
        .ld_byte    (ld_byte),
        .ld_last    (ld_last),
        .ld_ready   (ld_ready),
        .ld_count   (ld_count),
        .ld_ovf     (ld_ovf),
        .fetch_addr (fetch_addr),
        .fetch_dout (fetch_dout),
        .cpu_stall  (cpu_stall),
        .addr_err   (addr_err),
`ifdef IM_BOOT_CHECKSUM_EN
        .ld_sum     (ld_sum),
`endif
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    assign mem_rdata = ram[mem_addr];

    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
            wlog_a.push_back(int'(mem_addr));
            wlog_d.push_back(mem_wdata);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int k);
        logic [31:0] w = 32'h0;
        for (int j = 0; j < 4; j++) begin
            int i = 4 * k + j;
            w = (w << 8) | ((i < bq.size()) ? 32'(bq[i]) : 32'h0);
        end
        return w;
    endfunction

    function automatic int ref_nwords();
        int n = (bq.size() + 3) / 4;
        return (n > DEPTH) ? DEPTH : n;
    endfunction

    task automatic check_writes(input string tag);
        int nw = ref_nwords();
        chk({tag, "_nwrites"}, wlog_a.size(), nw);
        for (int k = 0; k < nw && k < wlog_a.size(); k++) begin
            chk($sformatf("%s_waddr%0d", tag, k), wlog_a[k], k);
            chk($sformatf("%s_wdata%0d", tag, k), wlog_d[k], ref_word(k));
        end
    endtask

    task automatic restart();
        @(negedge clk);
        ld_start = 1'b1;
        @(negedge clk);
        ld_start = 1'b0;
        chk("rs_stall", cpu_stall, 1);
        chk("rs_count", ld_count, 0);
        chk("rs_ready", ld_ready, 1);
        chk("rs_ovf", ld_ovf, 0);
        wlog_a.delete();
        wlog_d.delete();
    endtask

    // Streams bq with ld_last on the final byte, then checks the FLUSH/RUN handoff.
    task automatic send_image(input string tag);
        for (int i = 0; i < bq.size(); i++) begin
            @(negedge clk);
            ld_valid = 1'b1;
            ld_byte  = bq[i];
            ld_last  = (i == bq.size() - 1);
        end
        @(negedge clk);
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        chk({tag, "_we_flush"}, mem_we, 1);
        chk({tag, "_stall_flush"}, cpu_stall, 1);
        chk({tag, "_count"}, ld_count, ref_nwords());
        @(negedge clk);
        chk({tag, "_stall_run"}, cpu_stall, 0);
        chk({tag, "_ready_run"}, ld_ready, 0);
        chk({tag, "_we_run"}, mem_we, 0);
        check_writes(tag);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_stall"}, cpu_stall, 1);
        chk({tag, "_ready"}, ld_ready, 1);
        chk({tag, "_count"}, ld_count, 0);
        chk({tag, "_ovf"}, ld_ovf, 0);
        chk({tag, "_err"}, addr_err, 0);
        chk({tag, "_we"}, mem_we, 0);
        chk({tag, "_addr"}, mem_addr, 0);
        chk({tag, "_wdata"}, mem_wdata, 0);
        chk({tag, "_dout"}, fetch_dout, 0);
    endtask

    initial begin
        int nw;
        for (int i = 0; i < DEPTH; i++) ram[i] = 32'h0;

        fetch_addr = 30'h5;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("post_reset");

        bq = '{8'h34, 8'h01, 8'h00, 8'h04, 8'h34, 8'h02, 8'h00, 8'h01};
        send_image("img8");
`ifdef IM_BOOT_CHECKSUM_EN
        chk("img8_sum", ld_sum, 32'h68030005);
`endif

        fetch_addr = 30'h1;
        #1 chk("fetch1", fetch_dout, 32'h34020001);
        fetch_addr = 30'h0;
        #1 chk("fetch0", fetch_dout, 32'h34010004);
        chk("err_clean", addr_err, 0);
        fetch_addr = 30'h80;
        #1 chk("fetch_oor", fetch_dout, 32'h0);
        @(negedge clk);
        chk("addr_err", addr_err, 1);
        fetch_addr = 30'h0;
        #1 chk("err_sticky", addr_err, 1);
        fetch_addr = 30'(($urandom_range(1, 23'h7fffff) << 7) | $urandom_range(0, 127));
        #1 chk("fetch_oor_rand", fetch_dout, 32'h0);

        restart();
        chk("rs_dout", fetch_dout, 32'h0);
        bq = '{8'hAC, 8'h42, 8'h00, 8'h00, 8'h00};
        send_image("img5");

        for (int r = 0; r < 3; r++) begin
            restart();
            bq.delete();
            repeat ($urandom_range(1, 40)) bq.push_back(8'($urandom));
            send_image($sformatf("rnd%0d", r));
`ifdef IM_BOOT_CHECKSUM_EN
            begin
                logic [31:0] s = 32'h0;
                for (int k = 0; k < ref_nwords(); k++) s += ref_word(k);
                chk($sformatf("rnd%0d_sum", r), ld_sum, s);
            end
`endif
            nw = ref_nwords();
            for (int f = 0; f < 4; f++) begin
                int a = $urandom_range(0, nw - 1);
                fetch_addr = 30'(a);
                #1 chk($sformatf("rnd%0d_fetch%0d", r, f), fetch_dout, ref_word(a));
            end
        end

        restart();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            ld_valid = 1'b1;
            ld_byte  = 8'($urandom);
        end
        @(negedge clk);
        ld_start = 1'b1;
        ld_byte  = 8'hFF;
        @(negedge clk);
        ld_start = 1'b0;
        ld_valid = 1'b0;
        chk("abort_count", ld_count, 0);
        chk("abort_stall", cpu_stall, 1);
        bq = '{8'h00, 8'h43, 8'h10, 8'h21};
        send_image("abort");
        fetch_addr = 30'h0;
        #1 chk("abort_fetch", fetch_dout, 32'h00431021);

        restart();
        bq.delete();
        repeat (4 * DEPTH) bq.push_back(8'($urandom));
        for (int i = 0; i < 4 * DEPTH; i++) begin
            @(negedge clk);
            if (i % 64 == 0) chk($sformatf("ovf_ready%0d", i), ld_ready, 1);
            ld_valid = 1'b1;
            ld_byte  = bq[i];
        end
        @(negedge clk);
        chk("full_ready", ld_ready, 0);
        chk("full_count", ld_count, DEPTH);
        chk("full_ovf_pre", ld_ovf, 0);
        ld_byte = 8'($urandom);
        @(negedge clk);
        ld_valid = 1'b0;
        chk("ovf_set", ld_ovf, 1);
        chk("ovf_flush_stall", cpu_stall, 1);
        @(negedge clk);
        chk("ovf_run_stall", cpu_stall, 0);
        chk("ovf_count", ld_count, DEPTH);
        check_writes("ovf");
        fetch_addr = 30'(DEPTH - 1);
        #1 chk("ovf_fetch_last", fetch_dout, ref_word(DEPTH - 1));

        restart();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            ld_valid = 1'b1;
            ld_byte  = 8'($urandom);
        end
        @(negedge clk);
        ld_byte = 8'($urandom);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        ld_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_nowrite", wlog_a.size(), 0);
        check_reset_outputs("midrst_rel");

        bq = '{8'h34, 8'h01, 8'h00, 8'h04, 8'h34, 8'h02, 8'h00, 8'h01};
        send_image("reload");
`ifdef IM_BOOT_CHECKSUM_EN
        chk("reload_sum", ld_sum, 32'h68030005);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
